// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter and sequencer that shares one single-ported data memory
// between requester A (core load/store) and requester B (I/O / DMA).
module data_mem_arbiter #(
    parameter int ADDR_WIDTH = 14,
    parameter int DATA_WIDTH = 24
) (
    input  logic                  clk,
    input  logic                  reset_n,

    input  logic                  a_req_valid,
    input  logic                  a_req_write,
    input  logic [ADDR_WIDTH-1:0] a_req_addr,
    input  logic [DATA_WIDTH-1:0] a_req_wdata,
    output logic                  a_req_ready,
    output logic                  a_resp_valid,
    output logic [DATA_WIDTH-1:0] a_resp_rdata,

    input  logic                  b_req_valid,
    input  logic                  b_req_write,
    input  logic [ADDR_WIDTH-1:0] b_req_addr,
    input  logic [DATA_WIDTH-1:0] b_req_wdata,
    output logic                  b_req_ready,
    output logic                  b_resp_valid,
    output logic [DATA_WIDTH-1:0] b_resp_rdata,

    output logic                  mem_write_enable,
    output logic                  mem_read_enable,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_write_data,
    input  logic [DATA_WIDTH-1:0] mem_read_data
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESP
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_A,
        OWN_B
    } owner_t;

    state_t                state;
    state_t                state_next;
    owner_t                owner;
    logic                  last_grant_b;
    logic                  wr_flag;
    logic                  grant_a;
    logic                  grant_b;
    logic [DATA_WIDTH-1:0] a_rdata_q;
    logic [DATA_WIDTH-1:0] b_rdata_q;

    // NOTE: every signal gets a default before any branch so always_comb never infers a latch.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (state == IDLE) begin
            if (a_req_valid && b_req_valid) begin
                grant_a = last_grant_b;
                grant_b = !last_grant_b;
            end else begin
                grant_a = a_req_valid;
                grant_b = b_req_valid;
            end
        end
    end

    // Ready is masked while reset is held so nothing looks accepted during reset.
    always_comb begin
        a_req_ready = grant_a && reset_n;
        b_req_ready = grant_b && reset_n;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (grant_a || grant_b) state_next = ISSUE;
            ISSUE:   state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            owner          <= OWN_NONE;
            last_grant_b   <= 1'b1;
            wr_flag        <= 1'b0;
            mem_address    <= '0;
            mem_write_data <= '0;
            a_rdata_q      <= '0;
            b_rdata_q      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_a) begin
                        owner          <= OWN_A;
                        last_grant_b   <= 1'b0;
                        wr_flag        <= a_req_write;
                        mem_address    <= a_req_addr;
                        mem_write_data <= a_req_wdata;
                    end else if (grant_b) begin
                        owner          <= OWN_B;
                        last_grant_b   <= 1'b1;
                        wr_flag        <= b_req_write;
                        mem_address    <= b_req_addr;
                        mem_write_data <= b_req_wdata;
                    end
                end
                RESP: begin
                    // Keep the delivered read word so the owner's rdata stays stable afterwards.
                    if (!wr_flag && owner == OWN_A) a_rdata_q <= mem_read_data;
                    if (!wr_flag && owner == OWN_B) b_rdata_q <= mem_read_data;
                    owner <= OWN_NONE;
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        mem_write_enable = (state == ISSUE) && wr_flag;
        mem_read_enable  = (state == ISSUE) && !wr_flag;
        a_resp_valid     = (state == RESP) && (owner == OWN_A);
        b_resp_valid     = (state == RESP) && (owner == OWN_B);
        a_resp_rdata     = (a_resp_valid && !wr_flag) ? mem_read_data : a_rdata_q;
        b_resp_rdata     = (b_resp_valid && !wr_flag) ? mem_read_data : b_rdata_q;
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a behavioural data memory and a
// response scoreboard fed when requests are driven.
module tb_data_mem_arbiter;

    localparam int AW = 14;
    localparam int DW = 24;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          a_req_valid = 1'b0, a_req_write = 1'b0;
    logic [AW-1:0] a_req_addr = '0;
    logic [DW-1:0] a_req_wdata = '0;
    logic          a_req_ready, a_resp_valid;
    logic [DW-1:0] a_resp_rdata;
    logic          b_req_valid = 1'b0, b_req_write = 1'b0;
    logic [AW-1:0] b_req_addr = '0;
    logic [DW-1:0] b_req_wdata = '0;
    logic          b_req_ready, b_resp_valid;
    logic [DW-1:0] b_resp_rdata;
    logic          mem_write_enable, mem_read_enable;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_write_data;
    logic [DW-1:0] mem_read_data = '0;

    data_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .reset_n(reset_n),
        .a_req_valid(a_req_valid), .a_req_write(a_req_write), .a_req_addr(a_req_addr),
        .a_req_wdata(a_req_wdata), .a_req_ready(a_req_ready), .a_resp_valid(a_resp_valid),
        .a_resp_rdata(a_resp_rdata),
        .b_req_valid(b_req_valid), .b_req_write(b_req_write), .b_req_addr(b_req_addr),
        .b_req_wdata(b_req_wdata), .b_req_ready(b_req_ready), .b_resp_valid(b_resp_valid),
        .b_resp_rdata(b_resp_rdata),
        .mem_write_enable(mem_write_enable), .mem_read_enable(mem_read_enable),
        .mem_address(mem_address), .mem_write_data(mem_write_data),
        .mem_read_data(mem_read_data)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem_model [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (mem_write_enable) mem_model[mem_address] <= mem_write_data;
        if (mem_read_enable)  mem_read_data <= mem_model[mem_address];
    end

    typedef struct {
        bit            is_a;
        bit            is_read;
        logic [DW-1:0] rdata;
    } exp_t;

    exp_t sb[$];
    bit   grant_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc = 0;
    int   a_acc_cnt = 0, b_acc_cnt = 0;
    int   a_acc_cyc = 0, b_acc_cyc = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (reset_n) begin
            check("enables_exclusive", 32'(mem_write_enable & mem_read_enable), 0);
            check("ready_exclusive", 32'(a_req_ready & b_req_ready), 0);
            if (a_req_valid && a_req_ready) begin
                a_acc_cnt++; a_acc_cyc = cyc; grant_q.push_back(1'b1);
            end
            if (b_req_valid && b_req_ready) begin
                b_acc_cnt++; b_acc_cyc = cyc; grant_q.push_back(1'b0);
            end
            if (a_resp_valid || b_resp_valid) begin
                check("resp_one_hot", 32'(a_resp_valid & b_resp_valid), 0);
                if (sb.size() == 0) begin
                    check("resp_unexpected", 32'(a_resp_valid | b_resp_valid), 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("resp_owner_a", 32'(a_resp_valid), 32'(e.is_a));
                    check("resp_owner_b", 32'(b_resp_valid), 32'(!e.is_a));
                    if (e.is_read)
                        check("resp_rdata", e.is_a ? a_resp_rdata : b_resp_rdata, e.rdata);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input bit is_a, input bit is_read, input logic [DW-1:0] rdata);
        exp_t e;
        e.is_a = is_a; e.is_read = is_read; e.rdata = rdata;
        sb.push_back(e);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
        check(tag, sb.size(), 0);
        tick();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    task automatic check_grants(input string tag, input int n, input bit first_a);
        check({tag, "_count"}, grant_q.size(), n);
        for (int i = 0; i < n && i < grant_q.size(); i++)
            check($sformatf("%s_%0d", tag, i), 32'(grant_q[i]), 32'(first_a ^ i[0]));
    endtask

    initial begin
        int a_base, b_base, tot_base;

        // Reset state, with A trying to request while reset is held
        a_req_valid = 1'b1;
        tick();
        check("rst_a_ready", 32'(a_req_ready), 0);
        check("rst_mem_we", 32'(mem_write_enable), 0);
        check("rst_mem_re", 32'(mem_read_enable), 0);
        check("rst_mem_addr", 32'(mem_address), 0);
        check("rst_mem_wdata", mem_write_data, 0);
        check("rst_resp", 32'({a_resp_valid, b_resp_valid}), 0);
        check("rst_rdata", {a_resp_rdata, 8'h0} | 32'(b_resp_rdata), 0);
        a_req_valid = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();

        // A write 0xFFFF10 to 0x0005
        a_req_valid = 1'b1; a_req_write = 1'b1; a_req_addr = 14'h0005; a_req_wdata = 24'hFFFF10;
        push_exp(1'b1, 1'b0, '0);
        #1;
        check("wr_a_ready", 32'(a_req_ready), 1);
        check("wr_b_ready", 32'(b_req_ready), 0);
        tick();
        a_req_valid = 1'b0;
        #1;
        check("wr_issue_we", 32'(mem_write_enable), 1);
        check("wr_issue_re", 32'(mem_read_enable), 0);
        check("wr_issue_addr", 32'(mem_address), 32'h0005);
        check("wr_issue_wdata", mem_write_data, 32'hFFFF10);
        check("wr_issue_a_ready", 32'(a_req_ready), 0);
        tick();
        check("wr_resp_a_valid", 32'(a_resp_valid), 1);
        check("wr_resp_b_valid", 32'(b_resp_valid), 0);
        check("wr_resp_enables", 32'({mem_write_enable, mem_read_enable}), 0);
        tick();
        check("wr_idle_a_valid", 32'(a_resp_valid), 0);
        check("wr_idle_addr_hold", 32'(mem_address), 32'h0005);
        check("wr_idle_wdata_hold", mem_write_data, 32'hFFFF10);
        check("wr_b_rdata", b_resp_rdata, 0);

        // A read-back of 0x0005
        a_req_valid = 1'b1; a_req_write = 1'b0;
        push_exp(1'b1, 1'b1, 24'hFFFF10);
        #1;
        check("rd_a_ready", 32'(a_req_ready), 1);
        tick();
        a_req_valid = 1'b0;
        #1;
        check("rd_issue_re", 32'(mem_read_enable), 1);
        check("rd_issue_we", 32'(mem_write_enable), 0);
        check("rd_issue_addr", 32'(mem_address), 32'h0005);
        tick();
        check("rd_resp_a_valid", 32'(a_resp_valid), 1);
        check("rd_resp_a_rdata", a_resp_rdata, 32'hFFFF10);
        drain("rd_drain");
        check("rd_b_rdata", b_resp_rdata, 0);

        // Simultaneous writes right after reset: A first, B three cycles later
        do_reset();
        grant_q.delete();
        a_req_valid = 1'b1; a_req_write = 1'b1; a_req_addr = 14'h0010; a_req_wdata = 24'h000001;
        b_req_valid = 1'b1; b_req_write = 1'b1; b_req_addr = 14'h0011; b_req_wdata = 24'h000002;
        push_exp(1'b1, 1'b0, '0);
        push_exp(1'b0, 1'b0, '0);
        #1;
        check("sim_a_ready", 32'(a_req_ready), 1);
        check("sim_b_ready", 32'(b_req_ready), 0);
        a_base = a_acc_cnt; b_base = b_acc_cnt;
        for (int i = 0; i < 30 && (a_req_valid || b_req_valid); i++) begin
            tick();
            if (a_acc_cnt > a_base) a_req_valid = 1'b0;
            if (b_acc_cnt > b_base) b_req_valid = 1'b0;
        end
        check("sim_accept_timeout", 32'({a_req_valid, b_req_valid}), 0);
        check("sim_b_after_a", b_acc_cyc - a_acc_cyc, 3);
        drain("sim_drain");
        check_grants("sim_grant", 2, 1'b1);

        // Fairness: both read continuously for 12 accepts, memory readback verified
        grant_q.delete();
        a_req_valid = 1'b1; a_req_write = 1'b0; a_req_addr = 14'h0010;
        b_req_valid = 1'b1; b_req_write = 1'b0; b_req_addr = 14'h0011;
        for (int i = 0; i < 12; i++)
            push_exp(!i[0], 1'b1, i[0] ? 24'h000002 : 24'h000001);
        tot_base = a_acc_cnt + b_acc_cnt;
        for (int i = 0; i < 60 && (a_acc_cnt + b_acc_cnt) < tot_base + 12; i++) tick();
        a_req_valid = 1'b0; b_req_valid = 1'b0;
        check("fair_accepts", a_acc_cnt + b_acc_cnt - tot_base, 12);
        drain("fair_drain");
        check_grants("fair_grant", 12, 1'b1);

        // Withdrawal: B valid for one cycle during A's ISSUE
        b_base = b_acc_cnt;
        a_req_valid = 1'b1; a_req_write = 1'b0; a_req_addr = 14'h0011;
        push_exp(1'b1, 1'b1, 24'h000002);
        #1;
        check("wd_a_ready", 32'(a_req_ready), 1);
        tick();
        a_req_valid = 1'b0;
        b_req_valid = 1'b1; b_req_write = 1'b1; b_req_addr = 14'h3FFF; b_req_wdata = 24'h0BAD00;
        #1;
        check("wd_issue_b_ready", 32'(b_req_ready), 0);
        check("wd_issue_addr", 32'(mem_address), 32'h0011);
        tick();
        b_req_valid = 1'b0;
        #1;
        check("wd_resp_b_ready", 32'(b_req_ready), 0);
        check("wd_resp_b_valid", 32'(b_resp_valid), 0);
        drain("wd_drain");
        tick();
        check("wd_no_b_accept", b_acc_cnt - b_base, 0);
        check("wd_addr_not_b", 32'(mem_address), 32'h0011);

        // Async reset during an A read's ISSUE cycle
        a_req_valid = 1'b1; a_req_write = 1'b0; a_req_addr = 14'h0010;
        #1;
        check("ar_a_ready", 32'(a_req_ready), 1);
        tick();
        a_req_valid = 1'b0;
        #1;
        check("ar_issue_re", 32'(mem_read_enable), 1);
        reset_n = 1'b0;
        #1;
        check("ar_re_dropped", 32'(mem_read_enable), 0);
        check("ar_addr_cleared", 32'(mem_address), 0);
        check("ar_a_resp", 32'(a_resp_valid), 0);
        tick();
        check("ar_hold_a_resp", 32'(a_resp_valid), 0);
        tick();
        reset_n = 1'b1;
        b_req_valid = 1'b1; b_req_write = 1'b0; b_req_addr = 14'h0011;
        push_exp(1'b0, 1'b1, 24'h000002);
        #1;
        check("ar_b_ready_first_idle", 32'(b_req_ready), 1);
        check("ar_post_a_resp", 32'(a_resp_valid), 0);
        tick();
        b_req_valid = 1'b0;
        drain("ar_drain");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
